adaptation_step_controller: RTL and testbench
=============================================

ADAPTATION_STEP_CONTROLLER -- requirements
Module: adaptation_step_controller

Interface
REQ-001 SHALL have parameters (name, default, meaning): FXP_WIDTH, 16, metric/mu width; FXP_FRAC, 8, fraction bits (Q8.8).
REQ-002 SHALL have parameters: MU_INIT, 16'h0040, reset/re-acquire step size; MU_MIN, 16'h0002, floor; MU_MAX, 16'h0080, ceiling.
REQ-003 SHALL have parameters: SNR_TH, 16'h0400, track threshold; SNR_HYST, 16'h0080, hysteresis; STAB_MIN, 16'h0010, minimum stability_factor; SETTLE_CNT, 8, good samples to lock; FREEZE_CNT, 16, freeze length in samples.
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 synchronous active-high reset (one clock, reset synchronous and active-high).
REQ-005 SHALL have ports: metrics_valid input 1; metrics_ready output 1; snr_estimate, convergence_rate, stability_factor input FXP_WIDTH signed Q8.8 each, sampled on metrics handshake.
REQ-006 SHALL have ports: mu_out output FXP_WIDTH unsigned Q8.8; mu_valid output 1; mu_ready input 1.
REQ-007 SHALL have ports: state_out output 2 (ACQUIRE=0, TRACK=1, FREEZE=2, RECOVER=3); freeze_flag output 1; update_count output 16.

Function
REQ-008 Metrics sample SHALL be accepted when metrics_valid && metrics_ready; metrics_ready = !mu_valid || mu_ready (one-deep output buffer, no bubble).
REQ-009 On acceptance at edge N, mu_out, state_out and freeze_flag SHALL update and mu_valid SHALL be 1 after edge N (latency 1 cycle).
REQ-010 mu_valid SHALL stay 1 and mu_out stable until mu_valid && mu_ready; with no new acceptance on that edge mu_valid SHALL drop to 0.
REQ-011 Simultaneous output handshake and new acceptance SHALL keep mu_valid at 1 with the new mu_out.
REQ-012 update_count SHALL increment on each mu_valid && mu_ready, wrapping 16'hFFFF -> 0.
REQ-013 All threshold comparisons SHALL be signed; lower threshold = SNR_TH - SNR_HYST.
REQ-014 mu arithmetic SHALL be unsigned in 17 bits, then clamped to [MU_MIN, MU_MAX] before registering.
REQ-015 ACQUIRE: snr >= SNR_TH increments good_cnt, else good_cnt <= 0; mu held; good_cnt reaching SETTLE_CNT SHALL go to TRACK with mu <= mu>>1 (clamped), good_cnt <= 0.
REQ-016 TRACK: stability_factor < STAB_MIN SHALL go to FREEZE (highest priority), frz_cnt <= FREEZE_CNT-1, mu held.
REQ-017 TRACK otherwise: snr < lower threshold SHALL go to RECOVER, rec_cnt <= 0, mu held; else convergence_rate < 0 -> mu - (mu>>2); > 0 -> mu + (mu>>3); = 0 -> hold.
REQ-018 FREEZE: mu held, freeze_flag=1; frz_cnt != 0 decrements per accepted sample; at frz_cnt == 0, stability >= STAB_MIN -> TRACK, else reload FREEZE_CNT-1 and stay.
REQ-019 RECOVER: instability -> FREEZE as REQ-016; else snr >= SNR_TH -> TRACK, mu held; else mu + (mu>>1) clamped, rec_cnt++; rec_cnt reaching 2*SETTLE_CNT SHALL go to ACQUIRE with mu <= MU_INIT, good_cnt <= 0.
REQ-020 State, mu and counters SHALL change only on accepted samples; freeze_flag = (state == FREEZE), registered.
REQ-021 Unused encodings SHALL not occur; recovery from any illegal state SHALL be to ACQUIRE with mu <= MU_INIT.

Reset
REQ-022 rst high at an edge SHALL set mu_out=MU_INIT, mu_valid=0, state ACQUIRE, freeze_flag=0, update_count=0, good/frz/rec counters 0, overriding any concurrent handshake.
REQ-023 metrics_ready SHALL be 1 on the first cycle after reset release; reset mid-transfer SHALL discard the pending mu_out.

Verification
REQ-024 Bench SHALL drive 8 samples snr=16'h0500, conv=0, stab=16'h0100, mu_ready=1 -> state TRACK after 8th, mu_out=16'h0020, update_count=8.
REQ-025 Bench SHALL, in TRACK with mu=16'h0020, apply conv=-1 -> mu 16'h0018; conv=+1 from 16'h0080 -> mu stays 16'h0080 (clamp).
REQ-026 Bench SHALL, in TRACK, apply stab=16'h0008 -> FREEZE, freeze_flag=1; 16 samples with stab=16'h0100 -> TRACK after 16th, mu unchanged.
REQ-027 Bench SHALL hold mu_ready=0 with metrics_valid=1 -> metrics_ready=0 after first acceptance, mu_out stable; release -> one transfer per cycle, no sample lost.
REQ-028 Bench SHALL, in TRACK, apply snr=16'h0300 then 16 samples snr=16'h0300 -> RECOVER then ACQUIRE, mu_out=16'h0040.
REQ-029 Bench SHALL assert rst for 1 cycle with mu_valid=1, mu_ready=0 -> all REQ-022 values next cycle.

Source files
------------

// File: rtl/adaptation_step_controller.sv
// Adaptive step-size (mu) controller: moves between acquire, track, freeze
// and recover phases on each accepted metrics sample, one-deep mu output.
module adaptation_step_controller #(
  parameter int FXP_WIDTH = 16,
  parameter int FXP_FRAC = 8,
  parameter logic [FXP_WIDTH-1:0] MU_INIT = 16'h0040,
  parameter logic [FXP_WIDTH-1:0] MU_MIN = 16'h0002,
  parameter logic [FXP_WIDTH-1:0] MU_MAX = 16'h0080,
  parameter logic [FXP_WIDTH-1:0] SNR_TH = 16'h0400,
  parameter logic [FXP_WIDTH-1:0] SNR_HYST = 16'h0080,
  parameter logic [FXP_WIDTH-1:0] STAB_MIN = 16'h0010,
  parameter int SETTLE_CNT = 8,
  parameter int FREEZE_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 metrics_valid,
  output logic                 metrics_ready,
  input  logic [FXP_WIDTH-1:0] snr_estimate,
  input  logic [FXP_WIDTH-1:0] convergence_rate,
  input  logic [FXP_WIDTH-1:0] stability_factor,
  output logic [FXP_WIDTH-1:0] mu_out,
  output logic                 mu_valid,
  input  logic                 mu_ready,
  output logic [1:0]           state_out,
  output logic                 freeze_flag,
  output logic [15:0]          update_count
);

  if (FXP_FRAC >= FXP_WIDTH) begin : g_bad_frac
    $error("FXP_FRAC must be smaller than FXP_WIDTH");
  end

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FREEZE  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  localparam int W = FXP_WIDTH;
  localparam logic signed [W-1:0] TH_HI = SNR_TH;
  localparam logic signed [W-1:0] TH_LO = SNR_TH - SNR_HYST;
  localparam logic signed [W-1:0] STAB_S = STAB_MIN;
  localparam logic [15:0] SETTLE_L = 16'(SETTLE_CNT);
  localparam logic [15:0] RECOV_L = 16'(2 * SETTLE_CNT);
  localparam logic [15:0] FRZ_L = 16'(FREEZE_CNT - 1);

  state_e      state_q, state_d;
  logic [W-1:0] mu_q, mu_d;
  logic        mu_valid_q, mu_valid_d;
  logic        freeze_q, freeze_d;
  logic [15:0] upd_q, upd_d;
  logic [15:0] good_q, good_d;
  logic [15:0] frz_q, frz_d;
  logic [15:0] rec_q, rec_d;

  logic signed [W-1:0] snr_s, conv_s, stab_s;
  logic [W:0]  mu_x;
  logic        accept, unstable;

  function automatic logic [W-1:0] clamp(input logic [W:0] v);
    if (v < {1'b0, MU_MIN}) return MU_MIN;
    if (v > {1'b0, MU_MAX}) return MU_MAX;
    return v[W-1:0];
  endfunction

  assign snr_s = snr_estimate;
  assign conv_s = convergence_rate;
  assign stab_s = stability_factor;
  assign mu_x = {1'b0, mu_q};
  assign unstable = stab_s < STAB_S;

  assign metrics_ready = !mu_valid_q || mu_ready;
  assign accept = metrics_valid && metrics_ready;

  always_comb begin
    state_d = state_q;
    mu_d = mu_q;
    good_d = good_q;
    frz_d = frz_q;
    rec_d = rec_q;
    if (accept) begin
      case (state_q)
        ACQUIRE: begin
          if (snr_s >= TH_HI) begin
            if (good_q + 16'd1 == SETTLE_L) begin
              state_d = TRACK;
              mu_d = clamp(mu_x >> 1);
              good_d = '0;
            end else begin
              good_d = good_q + 16'd1;
            end
          end else begin
            good_d = '0;
          end
        end
        TRACK: begin
          if (unstable) begin
            state_d = FREEZE;
            frz_d = FRZ_L;
          end else if (snr_s < TH_LO) begin
            state_d = RECOVER;
            rec_d = '0;
          end else if (conv_s < 0) begin
            mu_d = clamp(mu_x - (mu_x >> 2));
          end else if (conv_s > 0) begin
            mu_d = clamp(mu_x + (mu_x >> 3));
          end
        end
        FREEZE: begin
          if (frz_q != 16'd0) begin
            frz_d = frz_q - 16'd1;
          end else if (!unstable) begin
            state_d = TRACK;
          end else begin
            frz_d = FRZ_L;
          end
        end
        RECOVER: begin
          if (unstable) begin
            state_d = FREEZE;
            frz_d = FRZ_L;
          end else if (snr_s >= TH_HI) begin
            state_d = TRACK;
          end else if (rec_q + 16'd1 == RECOV_L) begin
            state_d = ACQUIRE;
            mu_d = MU_INIT;
            good_d = '0;
            rec_d = '0;
          end else begin
            mu_d = clamp(mu_x + (mu_x >> 1));
            rec_d = rec_q + 16'd1;
          end
        end
        default: begin
          state_d = ACQUIRE;
          mu_d = MU_INIT;
        end
      endcase
    end
  end

  // Output buffer: a new sample refills it even on the draining edge.
  always_comb begin
    mu_valid_d = mu_valid_q;
    if (accept) mu_valid_d = 1'b1;
    else if (mu_ready) mu_valid_d = 1'b0;
    upd_d = upd_q;
    if (mu_valid_q && mu_ready) upd_d = upd_q + 16'd1;
    freeze_d = (state_d == FREEZE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQUIRE;
      mu_q <= MU_INIT;
      mu_valid_q <= 1'b0;
      freeze_q <= 1'b0;
      upd_q <= '0;
      good_q <= '0;
      frz_q <= '0;
      rec_q <= '0;
    end else begin
      state_q <= state_d;
      mu_q <= mu_d;
      mu_valid_q <= mu_valid_d;
      freeze_q <= freeze_d;
      upd_q <= upd_d;
      good_q <= good_d;
      frz_q <= frz_d;
      rec_q <= rec_d;
    end
  end

  assign mu_out = mu_q;
  assign mu_valid = mu_valid_q;
  assign state_out = state_q;
  assign freeze_flag = freeze_q;
  assign update_count = upd_q;

endmodule

// File: tb/tb_adaptation_step_controller.sv
// Directed bench for adaptation_step_controller.
// Expected values are hand-derived from the step-size rules.
module tb_adaptation_step_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        metrics_valid;
  logic        metrics_ready;
  logic [15:0] snr_estimate;
  logic [15:0] convergence_rate;
  logic [15:0] stability_factor;
  logic [15:0] mu_out;
  logic        mu_valid;
  logic        mu_ready;
  logic [1:0]  state_out;
  logic        freeze_flag;
  logic [15:0] update_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] u0;

  always #5 clk = ~clk;

  adaptation_step_controller dut (
    .clk(clk),
    .rst(rst),
    .metrics_valid(metrics_valid),
    .metrics_ready(metrics_ready),
    .snr_estimate(snr_estimate),
    .convergence_rate(convergence_rate),
    .stability_factor(stability_factor),
    .mu_out(mu_out),
    .mu_valid(mu_valid),
    .mu_ready(mu_ready),
    .state_out(state_out),
    .freeze_flag(freeze_flag),
    .update_count(update_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] snr, input logic [15:0] conv,
                      input logic [15:0] stab);
    int n;
    @(negedge clk);
    snr_estimate = snr;
    convergence_rate = conv;
    stability_factor = stab;
    metrics_valid = 1'b1;
    n = 0;
    while (!metrics_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    metrics_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    metrics_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    metrics_valid = 1'b0;
    mu_ready = 1'b1;
    snr_estimate = '0;
    convergence_rate = '0;
    stability_factor = 16'h0100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mu", mu_out, 16'h0040);
    check("rst_valid", mu_valid, 0);
    check("rst_state", state_out, 0);
    check("rst_freeze", freeze_flag, 0);
    check("rst_upd", update_count, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", metrics_ready, 1);

    // acquire: lock after 8 good samples
    for (int i = 0; i < 7; i++) send(16'h0500, 16'h0000, 16'h0100);
    check("acq_7_state", state_out, 0);
    check("acq_7_mu", mu_out, 16'h0040);
    send(16'h0500, 16'h0000, 16'h0100);
    check("acq_8_state", state_out, 1);
    check("acq_8_mu", mu_out, 16'h0020);
    check("acq_8_valid", mu_valid, 1);
    idle();
    check("acq_upd", update_count, 8);
    check("acq_drain", mu_valid, 0);

    // track step rules and ceiling
    send(16'h0500, 16'hFFFF, 16'h0100);
    check("trk_dec", mu_out, 16'h0018);
    send(16'h0500, 16'h0001, 16'h0100);
    check("trk_inc", mu_out, 16'h001B);
    for (int i = 0; i < 30; i++) send(16'h0500, 16'h0001, 16'h0100);
    check("trk_ceiling", mu_out, 16'h0080);
    send(16'h0500, 16'h0001, 16'h0100);
    check("trk_clamp", mu_out, 16'h0080);
    check("trk_state", state_out, 1);

    // freeze for 16 samples
    send(16'h0500, 16'h0001, 16'h0008);
    check("frz_state", state_out, 2);
    check("frz_flag", freeze_flag, 1);
    for (int i = 0; i < 15; i++) send(16'h0500, 16'h0001, 16'h0100);
    check("frz_15_state", state_out, 2);
    check("frz_15_mu", mu_out, 16'h0080);
    send(16'h0500, 16'h0001, 16'h0100);
    check("frz_exit_state", state_out, 1);
    check("frz_exit_flag", freeze_flag, 0);
    check("frz_exit_mu", mu_out, 16'h0080);

    // backpressure: buffer holds until mu_ready returns
    idle();
    @(negedge clk);
    mu_ready = 1'b0;
    snr_estimate = 16'h0500;
    convergence_rate = 16'hFFFF;
    stability_factor = 16'h0100;
    metrics_valid = 1'b1;
    @(posedge clk);
    #1;
    check("bp_first_mu", mu_out, 16'h0060);
    u0 = update_count;
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_low", metrics_ready, 0);
    check("bp_mu_stable", mu_out, 16'h0060);
    check("bp_valid_held", mu_valid, 1);
    check("bp_upd_held", update_count, u0);
    @(negedge clk);
    mu_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_refill_mu", mu_out, 16'h0048);
    check("bp_refill_valid", mu_valid, 1);
    metrics_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_upd", update_count, u0 + 16'd2);
    check("bp_drain", mu_valid, 0);

    // recover then fall back to acquire
    send(16'h0300, 16'h0000, 16'h0100);
    check("rec_state", state_out, 3);
    check("rec_mu_hold", mu_out, 16'h0048);
    send(16'h0300, 16'h0000, 16'h0100);
    check("rec_mu_grow", mu_out, 16'h006C);
    for (int i = 0; i < 14; i++) send(16'h0300, 16'h0000, 16'h0100);
    check("rec_15_state", state_out, 3);
    check("rec_15_mu", mu_out, 16'h0080);
    send(16'h0300, 16'h0000, 16'h0100);
    check("rec_acq_state", state_out, 0);
    check("rec_acq_mu", mu_out, 16'h0040);

    // reset with a pending, stalled output
    idle();
    @(negedge clk);
    mu_ready = 1'b0;
    snr_estimate = 16'h0500;
    metrics_valid = 1'b1;
    @(posedge clk);
    #1;
    metrics_valid = 1'b0;
    check("pre_rst_valid", mu_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    mu_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", mu_valid, 0);
    check("mid_rst_mu", mu_out, 16'h0040);
    check("mid_rst_state", state_out, 0);
    check("mid_rst_freeze", freeze_flag, 0);
    check("mid_rst_upd", update_count, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", metrics_ready, 1);
    for (int i = 0; i < 7; i++) send(16'h0500, 16'h0000, 16'h0100);
    check("post_rst_good", state_out, 0);
    send(16'h0500, 16'h0000, 16'h0100);
    check("post_rst_lock", state_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
